// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter and pop scheduler in front of a shared FIFO; tracks occupancy itself.
// Latency: one cycle from req/pop_req sampled to registered gnt/fifo_push or fifo_pop/pop_ack.
// Backpressure: grants stall while count==depth or fifo_full; pops stall while count==0.
module fifo_rr_arbiter #(
    parameter int bits  = 32,
    parameter int depth = 16,
    parameter int drvrs = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [drvrs-1:0]               req,
    input  logic [drvrs*bits-1:0]          din,
    output logic [drvrs-1:0]               gnt,
    input  logic                           pop_req,
    output logic                           pop_ack,
    output logic                           fifo_push,
    output logic [bits-1:0]                fifo_din,
    output logic                           fifo_pop,
    input  logic                           fifo_full,
    output logic [$clog2(depth+1)-1:0]     count
);

    localparam int LW = $clog2(drvrs);
    localparam int CW = $clog2(depth + 1);

    logic [LW-1:0]   last;
    logic [LW-1:0]   win;
    logic            win_vld;
    logic [bits-1:0] win_dat;
    logic            push_ok;
    logic            pop_ok;
    int              best;

    // Distance of producer i from the slot right after the previous winner.
    function automatic int rr_dist(input int i, input int l);
        return (i + drvrs - 1 - l) % drvrs;
    endfunction

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        win_dat = '0;
        best    = drvrs;
        for (int i = 0; i < drvrs; i++) begin
            if (req[i] && (rr_dist(i, int'(last)) < best)) begin
                best    = rr_dist(i, int'(last));
                win     = LW'(i);
                win_vld = 1'b1;
                win_dat = din[i*bits +: bits];
            end
        end
    end

    // Decisions use the pre-edge count, so a pop at full frees a slot only for the next cycle.
    assign push_ok = win_vld && (count < CW'(depth)) && !fifo_full;
    assign pop_ok  = pop_req && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            fifo_push <= 1'b0;
            fifo_din  <= '0;
            fifo_pop  <= 1'b0;
            pop_ack   <= 1'b0;
            count     <= '0;
            last      <= LW'(drvrs - 1);
        end else begin
            gnt       <= push_ok ? ({{(drvrs-1){1'b0}}, 1'b1} << win) : '0;
            fifo_push <= push_ok;
            fifo_pop  <= pop_ok;
            pop_ack   <= pop_ok;
            if (push_ok) begin
                fifo_din <= win_dat;
                last     <= win;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed plus randomized bench for fifo_rr_arbiter against a cycle-level occupancy/round-robin model.
module tb_fifo_rr_arbiter;

    localparam int BITS  = 32;
    localparam int DEPTH = 16;
    localparam int DRVRS = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [DRVRS-1:0]        req = '0;
    logic [DRVRS*BITS-1:0]   din = '0;
    logic                    pop_req = 1'b0;
    logic                    fifo_full = 1'b0;
    logic [DRVRS-1:0]        gnt;
    logic                    pop_ack;
    logic                    fifo_push;
    logic [BITS-1:0]         fifo_din;
    logic                    fifo_pop;
    logic [CW-1:0]           count;

    int compared   = 0;
    int mismatched = 0;

    int               m_count = 0;
    int               m_last  = DRVRS - 1;
    logic [BITS-1:0]  m_din   = '0;

    fifo_rr_arbiter #(.bits(BITS), .depth(DEPTH), .drvrs(DRVRS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .pop_req   (pop_req),
        .pop_ack   (pop_ack),
        .fifo_push (fifo_push),
        .fifo_din  (fifo_din),
        .fifo_pop  (fifo_pop),
        .fifo_full (fifo_full),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".gnt"},   64'(gnt),       64'd0);
        chk({tag, ".push"},  64'(fifo_push), 64'd0);
        chk({tag, ".din"},   64'(fifo_din),  64'd0);
        chk({tag, ".pop"},   64'(fifo_pop),  64'd0);
        chk({tag, ".ack"},   64'(pop_ack),   64'd0);
        chk({tag, ".count"}, 64'(count),     64'd0);
    endtask

    task automatic model_reset();
        m_count = 0;
        m_last  = DRVRS - 1;
        m_din   = '0;
    endtask

    // Predict one edge from the current inputs, advance, then compare everything.
    task automatic tick(input string tag);
        int               win = -1;
        logic             e_push;
        logic             e_pop;
        logic [DRVRS-1:0] e_gnt = '0;
        for (int k = 1; k <= DRVRS; k++) begin
            if (win < 0 && req[(m_last + k) % DRVRS]) win = (m_last + k) % DRVRS;
        end
        e_push = (win >= 0) && (m_count < DEPTH) && !fifo_full;
        e_pop  = pop_req && (m_count > 0);
        if (e_push) begin
            e_gnt[win] = 1'b1;
            m_din      = din[win*BITS +: BITS];
            m_last     = win;
        end
        m_count = m_count + int'(e_push) - int'(e_pop);
        @(posedge clk);
        #1;
        chk({tag, ".gnt"},   64'(gnt),       64'(e_gnt));
        chk({tag, ".push"},  64'(fifo_push), 64'(e_push));
        chk({tag, ".din"},   64'(fifo_din),  64'(m_din));
        chk({tag, ".pop"},   64'(fifo_pop),  64'(e_pop));
        chk({tag, ".ack"},   64'(pop_ack),   64'(e_pop));
        chk({tag, ".count"}, 64'(count),     64'(m_count));
    endtask

    initial begin
        // Reset held with everything requesting.
        req     = 4'b1111;
        pop_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b1;
        tick("first");
        chk("first.gnt_const", 64'(gnt), 64'd1);
        chk("underflow.pop", 64'(fifo_pop), 64'd0);
        pop_req = 1'b0;

        // Single producer streaming three words.
        req = 4'b0100;
        din[2*BITS +: BITS] = 32'hA; tick("single_a");
        din[2*BITS +: BITS] = 32'hB; tick("single_b");
        din[2*BITS +: BITS] = 32'hC; tick("single_c");
        chk("single.din_const", 64'(fifo_din), 64'hC);

        // Fairness with all requesting, then alternating pair.
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            for (int p = 0; p < DRVRS; p++) din[p*BITS +: BITS] = BITS'($urandom);
            tick("rr_all");
        end
        req = 4'b1010;
        tick("rr_pair0");
        chk("rr_pair0.gnt_const", 64'(gnt), 64'b1000);
        tick("rr_pair1");
        tick("rr_pair2");

        // Fill and hold at depth.
        req = 4'b0001;
        repeat (4) tick("fill");
        chk("fill.count_const", 64'(count), 64'd16);
        chk("fill.push_const", 64'(fifo_push), 64'd0);

        // Pop at full: pop only, grant resumes next edge.
        pop_req = 1'b1;
        tick("full_pop");
        chk("full_pop.count_const", 64'(count), 64'd15);
        pop_req = 1'b0;
        tick("full_regrant");
        chk("full_regrant.count_const", 64'(count), 64'd16);

        // Drain to 5, then push and pop together.
        req = '0;
        pop_req = 1'b1;
        repeat (11) tick("drain");
        req = 4'b0001;
        tick("both");
        chk("both.count_const", 64'(count), 64'd5);

        // Underflow guard.
        req = '0;
        repeat (7) tick("empty");
        chk("empty.pop_const", 64'(fifo_pop), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            req       = DRVRS'($urandom);
            for (int p = 0; p < DRVRS; p++) din[p*BITS +: BITS] = BITS'($urandom);
            pop_req   = ($urandom_range(0, 99) < 45);
            fifo_full = ($urandom_range(0, 99) < 10);
            tick("rand");
        end
        fifo_full = 1'b0;
        pop_req   = 1'b0;

        // Asynchronous reset between edges during a burst.
        req = 4'b1111;
        repeat (3) tick("burst");
        #2;
        rst = 1'b0;
        #1;
        chk_cleared("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("post_rst");
        chk("post_rst.gnt_const", 64'(gnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
